// File: rtl/multdiv_pkg.sv
// multdiv_pkg: shared constants and state type for the multicycle multiply/divide unit
package multdiv_pkg;
    localparam int WIDTH = 32;
    localparam int ITERS = WIDTH;
    localparam int CW = $clog2(ITERS) + 1;
    localparam logic [WIDTH-1:0] INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
    typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;
endpackage

// File: rtl/multdiv_unit_if.sv
// multdiv_unit_if: pipeline-side operand/control and result handshake of the multiply/divide unit
interface multdiv_unit_if;
    import multdiv_pkg::*;
    logic [WIDTH-1:0] data_operandA, data_operandB, data_result;
    logic ctrl_MULT, ctrl_DIV, data_exception, data_resultRDY, busy;
    modport master(
        output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        input  data_result, data_exception, data_resultRDY, busy
    );
    modport slave(
        input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        output data_result, data_exception, data_resultRDY, busy
    );
endinterface

// File: rtl/twos_negate.sv
// twos_negate: conditional two's-complement negate
module twos_negate import multdiv_pkg::*; (
    input  logic [WIDTH-1:0] a,
    input  logic             neg,
    output logic [WIDTH-1:0] y
);
    assign y = neg ? -a : a;
endmodule

// File: rtl/multdiv_unit.sv
// multdiv_unit: signed 32-bit Booth multiplier / restoring divider, one bit per cycle, fixed latency
module multdiv_unit import multdiv_pkg::*; (
    input logic           clock,
    input logic           reset,
    multdiv_unit_if.slave bus
);
    state_t state, state_n;
    logic [CW-1:0] cnt;
    logic [WIDTH:0] hi, hi_n, m_ext, booth_sum, shifted;
    logic [WIDTH-1:0] lo, lo_n, m, abs_a, abs_b, quo_fix, result;
    logic [2*WIDTH-1:0] prod;
    logic q_1, neg_q, exc, start, run, last, fin, ge;

    twos_negate u_abs_a (.a(bus.data_operandA), .neg(bus.data_operandA[WIDTH-1]), .y(abs_a));
    twos_negate u_abs_b (.a(bus.data_operandB), .neg(bus.data_operandB[WIDTH-1]), .y(abs_b));
    twos_negate u_quo   (.a(lo_n), .neg(neg_q), .y(quo_fix));

    assign start = bus.ctrl_MULT | bus.ctrl_DIV;
    assign run   = state == MULT || state == DIV;
    assign last  = cnt == CW'(ITERS - 1);
    assign fin   = run && last && !start;

    // hi is the Booth accumulator (one guard bit for -INT_MIN) or the divide remainder; lo is multiplier or quotient
    always_comb begin
        m_ext     = {m[WIDTH-1], m};
        booth_sum = (lo[0] & ~q_1) ? hi - m_ext : (~lo[0] & q_1) ? hi + m_ext : hi;
        shifted   = {hi[WIDTH-1:0], lo[WIDTH-1]};
        ge        = shifted >= {1'b0, m};
        hi_n      = state == MULT ? {booth_sum[WIDTH], booth_sum[WIDTH:1]} : ge ? shifted - {1'b0, m} : shifted;
        lo_n      = state == MULT ? {booth_sum[0], lo[WIDTH-1:1]} : {lo[WIDTH-2:0], ge};
        prod      = {hi_n[WIDTH-1:0], lo_n};
        state_n   = start ? (bus.ctrl_MULT ? MULT : DIV) : state == DONE ? IDLE : fin ? DONE : state;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            hi     <= '0;
            lo     <= '0;
            m      <= '0;
            q_1    <= 1'b0;
            neg_q  <= 1'b0;
            result <= '0;
            exc    <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= run && !start && !last ? cnt + CW'(1) : '0;
            if (start) begin
                hi    <= '0;
                q_1   <= 1'b0;
                lo    <= bus.ctrl_MULT ? bus.data_operandA : abs_a;
                m     <= bus.ctrl_MULT ? bus.data_operandB : abs_b;
                neg_q <= bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
            end else if (run) begin
                hi  <= hi_n;
                lo  <= lo_n;
                q_1 <= lo[0];
            end
            // only magnitude INT_MIN with a positive sign overflows: INT_MIN / -1
            if (fin) begin
                result <= state == MULT ? lo_n : m == '0 ? '0 : quo_fix;
                exc    <= state == MULT ? prod[2*WIDTH-1:WIDTH] != {WIDTH{lo_n[WIDTH-1]}}
                                        : m == '0 || (lo_n == INT_MIN && !neg_q);
            end
        end
    end

    assign bus.data_result    = result;
    assign bus.data_exception = exc;
    assign bus.data_resultRDY = state == DONE;
    assign bus.busy           = state != IDLE;
endmodule

// File: tb/tb_multdiv_unit.sv
// tb_multdiv_unit: directed and randomized checks of multdiv_unit against a cycle-level reference model
module tb_multdiv_unit;
    import multdiv_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;
    bit pend = 1'b0;
    int cyc = 0;
    logic [31:0] hold_res = '0, p_res = '0;
    logic hold_exc = 1'b0, p_exc = 1'b0;
    multdiv_unit_if bus();
    multdiv_unit dut (.clock(clk), .reset(rst), .bus(bus));
    always #5 clk = ~clk;

    function automatic logic [32:0] ref_op(input bit mul, input logic [31:0] a, input logic [31:0] b);
        longint p;
        if (mul) begin
            p = longint'($signed(a)) * longint'($signed(b));
            return {p != longint'($signed(p[31:0])), p[31:0]};
        end
        if (b == 32'h0) return {1'b1, 32'h0};
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {1'b1, 32'h80000000};
        return {1'b0, 32'($signed(a) / $signed(b))};
    endfunction

    task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference timing: ready is the 33rd cycle after the accepted start edge; results change only then
    always @(posedge clk) begin
        if (rst) begin
            pend = 1'b0;
            cyc = 0;
            hold_res = '0;
            hold_exc = 1'b0;
        end else if (bus.ctrl_MULT || bus.ctrl_DIV) begin
            pend = 1'b1;
            cyc = 1;
            {p_exc, p_res} = ref_op(bus.ctrl_MULT, bus.data_operandA, bus.data_operandB);
        end else if (pend) begin
            cyc++;
            if (cyc == ITERS + 1) {hold_exc, hold_res} = {p_exc, p_res};
            if (cyc > ITERS + 1) pend = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("rdy", bus.data_resultRDY, pend && cyc == ITERS + 1);
            chk("busy", bus.busy, pend);
            chk("result", bus.data_result, hold_res);
            chk("exc", bus.data_exception, hold_exc);
        end
    end

    task automatic start_op(input bit mul, input bit dv, input logic [31:0] a, input logic [31:0] b);
        bus.data_operandA = a;
        bus.data_operandB = b;
        bus.ctrl_MULT = mul;
        bus.ctrl_DIV = dv;
        @(negedge clk);
        bus.ctrl_MULT = 1'b0;
        bus.ctrl_DIV = 1'b0;
    endtask

    task automatic wait_rdy(output int lat);
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            if (bus.data_resultRDY) begin
                lat = n;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic run_op(input string name, input bit mul, input bit dv, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eres, input logic eexc);
        int lat;
        start_op(mul, dv, a, b);
        wait_rdy(lat);
        chk({name, "_lat"}, 33'(lat), 33'd33);
        chk({name, "_res"}, {1'b0, bus.data_result}, {1'b0, eres});
        chk({name, "_exc"}, {32'h0, bus.data_exception}, {32'h0, eexc});
        @(negedge clk);
        chk({name, "_rdy_off"}, {32'h0, bus.data_resultRDY}, 33'h0);
    endtask

    function automatic logic [31:0] rnd_opnd();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h80000000;
            2: return 32'hFFFFFFFF;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom();
        endcase
    endfunction

    initial begin
        logic [32:0] r;
        int lat, k, sel;
        bus.data_operandA = '0;
        bus.data_operandB = '0;
        bus.ctrl_MULT = 1'b0;
        bus.ctrl_DIV = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        chk("reset_result", {1'b0, bus.data_result}, 33'h0);
        chk("reset_busy", {bus.busy, bus.data_resultRDY}, 33'h0);
        r = ref_op(1'b1, 32'd7, 32'hFFFFFFFA);
        chk("pin_mul", r, {1'b0, 32'hFFFFFFD6});
        r = ref_op(1'b0, 32'hFFFFFF9C, 32'd7);
        chk("pin_div", r, {1'b0, 32'hFFFFFFF2});
        r = ref_op(1'b1, 32'h00010000, 32'h00010000);
        chk("pin_mul_ovf", r, {1'b1, 32'h0});

        run_op("mul_7_m6", 1'b1, 1'b0, 32'd7, 32'hFFFFFFFA, 32'hFFFFFFD6, 1'b0);
        run_op("mul_ovf", 1'b1, 1'b0, 32'h00010000, 32'h00010000, 32'h0, 1'b1);
        run_op("mul_max", 1'b1, 1'b0, 32'h7FFFFFFF, 32'd1, 32'h7FFFFFFF, 1'b0);
        run_op("div_m100_7", 1'b0, 1'b1, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 1'b0);
        run_op("div_by0", 1'b0, 1'b1, 32'd5, 32'h0, 32'h0, 1'b1);
        run_op("div_ovf", 1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1);
        run_op("div_min_1", 1'b0, 1'b1, 32'h80000000, 32'd1, 32'h80000000, 1'b0);

        start_op(1'b0, 1'b1, 32'd100, 32'd3);
        repeat (9) @(negedge clk);
        run_op("restart", 1'b1, 1'b0, 32'd3, 32'd4, 32'd12, 1'b0);
        run_op("both_ctrl", 1'b1, 1'b1, 32'd8, 32'd2, 32'd16, 1'b0);

        start_op(1'b1, 1'b0, 32'd123, 32'd456);
        repeat (13) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_out", {bus.data_exception, bus.data_result}, 33'h0);
        chk("rst_mid_flags", {31'h0, bus.busy, bus.data_resultRDY}, 33'h0);
        wait_rdy(lat);
        chk("rst_no_rdy", 33'(lat), 33'd0);
        run_op("div_9_3", 1'b0, 1'b1, 32'd9, 32'd3, 32'd3, 1'b0);

        start_op(1'b1, 1'b0, 32'd3, 32'd5);
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            if (bus.data_resultRDY) begin
                lat = n;
                break;
            end
            bus.data_operandA = $urandom();
            bus.data_operandB = $urandom();
            @(negedge clk);
        end
        chk("hold_lat", 33'(lat), 33'd33);
        chk("hold_res", {1'b0, bus.data_result}, 33'd15);
        repeat (5) begin
            bus.data_operandA = $urandom();
            bus.data_operandB = $urandom();
            @(negedge clk);
        end
        chk("hold_keep", {bus.data_exception, bus.data_result}, 33'd15);

        for (int i = 0; i < 80; i++) begin
            sel = $urandom_range(0, 4);
            k = $urandom_range(1, 45);
            start_op(sel < 2 || sel == 4, sel >= 2, rnd_opnd(), rnd_opnd());
            repeat (k - 1) @(negedge clk);
        end
        repeat (40) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
